// File: rtl/force_reg_bank.sv
// Multi-slot force packet holding bank: buffers packets from the force pipeline and
// presents one at a time to write-back in round-robin slot order.
module force_reg_bank #(
    parameter int unsigned NUM_SLOTS         = 4,
    parameter int unsigned F_WIDTH           = 96,
    parameter int unsigned CELL_ID_WIDTH     = 3,
    parameter int unsigned PARTICLE_ID_WIDTH = 8,
    parameter int unsigned CID_WIDTH         = 3 * CELL_ID_WIDTH,
    parameter int unsigned PARID_WIDTH       = PARTICLE_ID_WIDTH,
    parameter int unsigned PKT_WIDTH         = F_WIDTH + CID_WIDTH + PARID_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_select,
    input  logic [F_WIDTH-1:0]                 i_force,
    input  logic [CID_WIDTH-1:0]               i_nb_cid,
    input  logic [PARID_WIDTH-1:0]             i_nb_parid,
    output logic                               o_in_ready,
    output logic                               o_valid,
    output logic [PKT_WIDTH-1:0]               o_reg,
    input  logic                               i_release_select,
    input  logic                               i_flush,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     o_occupancy,
    output logic                               o_overflow
);

    localparam int unsigned PTR_W = $clog2(NUM_SLOTS);
    localparam int unsigned OCC_W = $clog2(NUM_SLOTS + 1);

    logic [PKT_WIDTH-1:0] slot_data_q [NUM_SLOTS];
    logic [PKT_WIDTH-1:0] slot_data_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 ovf_q, ovf_d;

    logic [PTR_W-1:0]     head_c;
    logic                 head_found_c;
    logic [PTR_W-1:0]     free_c;
    logic                 free_found_c;
    logic                 full_c;
    logic                 any_c;
    logic                 wr_acc_c;
    logic                 rel_acc_c;
    logic [PKT_WIDTH-1:0] in_pkt_c;

    assign full_c   = &slot_vld_q;
    assign any_c    = |slot_vld_q;
    assign in_pkt_c = {i_force, i_nb_cid, i_nb_parid};

    // Head: first valid slot scanning upward from rr_ptr (wraps since NUM_SLOTS is 2^n).
    always_comb begin
        head_c       = '0;
        head_found_c = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!head_found_c && slot_vld_q[rr_ptr_q + PTR_W'(i)]) begin
                head_c       = rr_ptr_q + PTR_W'(i);
                head_found_c = 1'b1;
            end
        end
    end

    // Write target: lowest free slot.
    always_comb begin
        free_c       = '0;
        free_found_c = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!free_found_c && !slot_vld_q[i]) begin
                free_c       = PTR_W'(i);
                free_found_c = 1'b1;
            end
        end
    end

    // Readiness is judged on pre-edge state, so a release never makes room for a same-cycle write.
    assign wr_acc_c  = i_select & ~full_c;
    assign rel_acc_c = i_release_select & any_c;

    always_comb begin
        slot_data_d = slot_data_q;
        slot_vld_d  = slot_vld_q;
        rr_ptr_d    = rr_ptr_q;
        occ_d       = occ_q;
        ovf_d       = ovf_q;
        if (i_flush) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_data_d[i] = '0;
            end
            slot_vld_d = '0;
            rr_ptr_d   = '0;
            occ_d      = '0;
            ovf_d      = 1'b0;
        end else begin
            if (rel_acc_c) begin
                slot_vld_d[head_c]  = 1'b0;
                slot_data_d[head_c] = '0;
                rr_ptr_d            = head_c + PTR_W'(1);
            end
            // A valid head is never the free slot, so both updates can coexist.
            if (wr_acc_c) begin
                slot_vld_d[free_c]  = 1'b1;
                slot_data_d[free_c] = in_pkt_c;
            end
            if (i_select && full_c) begin
                ovf_d = 1'b1;
            end
            case ({wr_acc_c, rel_acc_c})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_data_q[i] <= '0;
            end
            slot_vld_q <= '0;
            rr_ptr_q   <= '0;
            occ_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_vld_q  <= slot_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            occ_q       <= occ_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_in_ready  = ~full_c;
    assign o_valid     = any_c;
    assign o_reg       = any_c ? slot_data_q[head_c] : '0;
    assign o_occupancy = occ_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_force_reg_bank.sv
// Bench for force_reg_bank: directed vector table, hand sequences for reset/flush,
// then random traffic checked against an array-based reference model.
module tb_force_reg_bank;

    localparam int N   = 4;
    localparam int FW  = 96;
    localparam int CW  = 9;
    localparam int PW  = 8;
    localparam int PKT = FW + CW + PW;
    localparam int OW  = 3;

    logic            clk;
    logic            rst;
    logic            i_select;
    logic [FW-1:0]   i_force;
    logic [CW-1:0]   i_nb_cid;
    logic [PW-1:0]   i_nb_parid;
    logic            o_in_ready;
    logic            o_valid;
    logic [PKT-1:0]  o_reg;
    logic            i_release_select;
    logic            i_flush;
    logic [OW-1:0]   o_occupancy;
    logic            o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    force_reg_bank #(
        .NUM_SLOTS(N), .F_WIDTH(FW), .CELL_ID_WIDTH(3), .PARTICLE_ID_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_select(i_select), .i_force(i_force), .i_nb_cid(i_nb_cid), .i_nb_parid(i_nb_parid),
        .o_in_ready(o_in_ready), .o_valid(o_valid), .o_reg(o_reg),
        .i_release_select(i_release_select), .i_flush(i_flush),
        .o_occupancy(o_occupancy), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a set of occupied slots plus a scan pointer.
    logic [PKT-1:0] m_data [N];
    bit             m_vld  [N];
    int             m_rr;
    bit             m_ovf;

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < N; k++) if (m_vld[k]) c++;
        return c;
    endfunction

    function automatic int m_head();
        for (int k = 0; k < N; k++) if (m_vld[(m_rr + k) % N]) return (m_rr + k) % N;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_data[k] = '0;
            m_vld[k]  = 0;
        end
        m_rr  = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit sel, input bit rel, input bit fl, input logic [PKT-1:0] pkt);
        int cnt, h, fr;
        if (fl) begin
            model_reset();
            return;
        end
        cnt = m_count();
        h   = m_head();
        fr  = -1;
        for (int k = N - 1; k >= 0; k--) if (!m_vld[k]) fr = k;
        if (rel && cnt > 0) begin
            m_vld[h]  = 0;
            m_data[h] = '0;
            m_rr      = (h + 1) % N;
        end
        if (sel) begin
            if (cnt == N) m_ovf = 1;
            else begin
                m_vld[fr]  = 1;
                m_data[fr] = pkt;
            end
        end
    endtask

    function automatic logic [PKT-1:0] mk_pkt(input logic [7:0] p);
        logic [31:0] w;
        w = {24'h0, p};
        return {32'h3F800000 ^ w, {p, p, p, p}, ~w, {1'b0, p}, p};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit ev, input logic [PKT-1:0] er,
                                 input bit erdy, input int eocc, input bit eovf);
        check($sformatf("%s.valid", tag),     128'(o_valid),     128'(ev));
        check($sformatf("%s.reg", tag),       128'(o_reg),       128'(er));
        check($sformatf("%s.in_ready", tag),  128'(o_in_ready),  128'(erdy));
        check($sformatf("%s.occupancy", tag), 128'(o_occupancy), 128'(eocc));
        check($sformatf("%s.overflow", tag),  128'(o_overflow),  128'(eovf));
    endtask

    task automatic check_model(input string tag);
        int c;
        c = m_count();
        check_outputs(tag, c > 0, (c > 0) ? m_data[m_head()] : '0, c < N, c, m_ovf);
    endtask

    // Called at a negedge; drives inputs, clocks once, returns at the next negedge.
    task automatic step(input bit sel, input bit rel, input bit fl, input logic [PKT-1:0] pkt);
        i_select         = sel;
        i_release_select = rel;
        i_flush          = fl;
        {i_force, i_nb_cid, i_nb_parid} = pkt;
        @(posedge clk);
        model_step(sel, rel, fl, pkt);
        @(negedge clk);
        i_select         = 1'b0;
        i_release_select = 1'b0;
        i_flush          = 1'b0;
    endtask

    typedef struct {
        bit         sel;
        bit         rel;
        bit         fl;
        logic [7:0] parid;
        bit         ev;
        int         eocc;
        bit         eovf;
        bit         erdy;
        logic [7:0] eparid;
    } vec_t;

    vec_t tbl [17];
    logic [PKT-1:0] sp;

    initial begin
        // sel rel fl parid | valid occ ovf ready presented-parid
        tbl[0]  = '{1, 0, 0, 8'd1,  1, 1, 0, 1, 8'd1};
        tbl[1]  = '{1, 0, 0, 8'd2,  1, 2, 0, 1, 8'd1};
        tbl[2]  = '{1, 0, 0, 8'd3,  1, 3, 0, 1, 8'd1};
        tbl[3]  = '{1, 0, 0, 8'd4,  1, 4, 0, 0, 8'd1};
        tbl[4]  = '{1, 0, 0, 8'd9,  1, 4, 1, 0, 8'd1};
        tbl[5]  = '{1, 1, 0, 8'd7,  1, 3, 1, 1, 8'd2};
        tbl[6]  = '{0, 1, 0, 8'd0,  1, 2, 1, 1, 8'd3};
        tbl[7]  = '{1, 0, 0, 8'd8,  1, 3, 1, 1, 8'd3};
        tbl[8]  = '{0, 1, 0, 8'd0,  1, 2, 1, 1, 8'd4};
        tbl[9]  = '{0, 1, 0, 8'd0,  1, 1, 1, 1, 8'd8};
        tbl[10] = '{0, 1, 0, 8'd0,  0, 0, 1, 1, 8'd0};
        tbl[11] = '{0, 1, 0, 8'd0,  0, 0, 1, 1, 8'd0};
        tbl[12] = '{1, 0, 0, 8'd5,  1, 1, 1, 1, 8'd5};
        tbl[13] = '{1, 0, 0, 8'd6,  1, 2, 1, 1, 8'd6};
        tbl[14] = '{1, 0, 0, 8'd10, 1, 3, 1, 1, 8'd6};
        tbl[15] = '{1, 1, 1, 8'd11, 0, 0, 0, 1, 8'd0};
        tbl[16] = '{0, 0, 0, 8'd0,  0, 0, 0, 1, 8'd0};

        rst = 1'b1;
        i_select = 1'b0; i_release_select = 1'b0; i_flush = 1'b0;
        i_force = '0; i_nb_cid = '0; i_nb_parid = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_outputs("reset", 0, '0, 1, 0, 0);

        sp = {96'h3F800000_40000000_C0000000, 9'h1A3, 8'd5};
        step(1, 0, 0, sp);
        check_outputs("single_wr", 1, sp, 1, 1, 0);
        step(0, 1, 0, sp);
        check_outputs("single_rel", 0, '0, 1, 0, 0);

        // Asynchronous reset between edges must clear everything at once.
        step(1, 0, 0, mk_pkt(8'd33));
        step(1, 0, 0, mk_pkt(8'd34));
        check_model("pre_async_rst");
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", 0, '0, 1, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 17; k++) begin
            step(tbl[k].sel, tbl[k].rel, tbl[k].fl, mk_pkt(tbl[k].parid));
            check_outputs($sformatf("vec%0d", k), tbl[k].ev,
                          tbl[k].ev ? mk_pkt(tbl[k].eparid) : '0,
                          tbl[k].erdy, tbl[k].eocc, tbl[k].eovf);
        end

        for (int c = 0; c < 400; c++) begin
            logic [PKT-1:0] rp;
            rp = {$urandom, $urandom, $urandom, 9'($urandom), 8'($urandom)};
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 31) == 0, rp);
            check_model($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/force_reg_bank.md
Name: force_reg_bank

Overview:
- Parametrised successor to the single-entry force packet register in the force-evaluation datapath.
- Holds up to NUM_SLOTS force packets (force value, neighbour cell ID, neighbour particle ID) produced by a force pipeline.
- Presents one held packet at a time to the force-write-back/accumulation stage, using round-robin slot order.
- Adds what the single register lacks: multi-slot buffering, ready back-pressure, occupancy reporting, flush, and sticky overflow detection.

Parameters:
- NUM_SLOTS, 4, number of packet slots; power of two, ≥2.
- F_WIDTH, 96, force field width (3 × 32-bit float components, float_data_t packing).
- CID_WIDTH, 3*CELL_ID_WIDTH, neighbour cell ID width.
- PARID_WIDTH, PARTICLE_ID_WIDTH, neighbour particle ID width.
- PKT_WIDTH, F_WIDTH+CID_WIDTH+PARID_WIDTH, packet width; packing {f, cid, parid}, with f in the MSBs (force_packet_t order).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- i_select, in, 1, write strobe; a packet is offered this cycle.
- i_force, in, F_WIDTH, force value.
- i_nb_cid, in, CID_WIDTH, neighbour cell ID.
- i_nb_parid, in, PARID_WIDTH, neighbour particle ID.
- o_in_ready, out, 1, at least one slot is free.
- o_valid, out, 1, o_reg holds a valid packet.
- o_reg, out, PKT_WIDTH, presented packet; all zeros when o_valid=0.
- i_release_select, in, 1, consumer accepts the presented packet.
- i_flush, in, 1, synchronous clear of all slots.
- o_occupancy, out, $clog2(NUM_SLOTS+1), number of valid slots.
- o_overflow, out, 1, sticky: a write was dropped because the bank was full.

Behaviour:
- State:
  - slot_data[NUM_SLOTS] and slot_vld[NUM_SLOTS].
  - rr_ptr, $clog2(NUM_SLOTS) bits.
  - occupancy counter.
  - overflow flag.
- Reset (async assert, rst=1): all slot_vld=0, slot_data=0, rr_ptr=0, occupancy=0, overflow=0. Resulting outputs: o_valid=0, o_reg=0, o_in_ready=1, o_occupancy=0, o_overflow=0. Reset mid-operation discards all held packets.
- Read side (combinational from registered state):
  - head = first index with slot_vld=1, scanning rr_ptr, rr_ptr+1, … mod NUM_SLOTS.
  - o_valid = |slot_vld.
  - o_reg = slot_data[head] if o_valid, else 0.
- Release: when i_release_select & o_valid at a clock edge:
  - slot_vld[head] ← 0 and slot_data[head] ← 0.
  - rr_ptr ← head+1 (mod NUM_SLOTS).
  - i_release_select with o_valid=0 is ignored.
- Write: when i_select & o_in_ready:
  - Target = lowest index with slot_vld=0, evaluated on pre-edge state.
  - slot_data ← {i_force, i_nb_cid, i_nb_parid}; slot_vld ← 1.
  - The packet is visible on o_reg no earlier than the next cycle (1-cycle write-to-present latency).
- o_in_ready = ~&slot_vld, computed from pre-edge state.
  - When full, a same-cycle release does NOT admit a write.
  - i_select while o_in_ready=0: packet dropped, overflow ← 1 (sticky until rst or i_flush).
- Simultaneous write and release (not full):
  - Both take effect.
  - The write target is never the released slot, since that slot was valid.
  - occupancy unchanged.
- Occupancy update: +1 on an accepted write, −1 on an accepted release, net 0 on both; never wraps.
- Flush (i_flush=1) has priority over everything:
  - All slot_vld=0 and slot_data=0; rr_ptr=0; occupancy=0; overflow=0.
  - A concurrent write is discarded without setting overflow.
  - A concurrent release is ignored.
- Round-robin order guarantees no slot is starved under continuous writes.
- Presentation order is slot order from rr_ptr, not arrival order; downstream must not assume FIFO ordering.
- Outputs glitch-free relative to clk: combinational only from registers.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) → o_valid=0, o_reg=0, o_in_ready=1, o_occupancy=0, o_overflow=0 immediately, without waiting for a clock edge.
- Single packet: i_select=1 with f=0x3F800000_40000000_C0000000, cid=0x1A3, parid=5 → next cycle o_valid=1 and o_reg equals that packing; o_occupancy=1. i_release_select for 1 cycle → o_valid=0, o_reg=0.
- Fill and overflow (NUM_SLOTS=4):
  - Write 4 packets with parid=1..4 → o_in_ready=0, o_occupancy=4.
  - 5th write with parid=9 → dropped; o_overflow=1 and stays 1; parid=9 never appears on o_reg.
- Full plus simultaneous write/release: with 4 slots full, assert i_select (parid=7) and i_release_select together → write dropped, overflow=1, occupancy=3.
- Round-robin: fill slots 0–3, release twice (slots 0, 1 → rr_ptr=2), write parid=8 (lands in slot 0) → next presentations in order: slot 2, slot 3, slot 0 (parid 8).
- Flush priority: occupancy=3 and overflow=1, then assert i_flush together with i_select and i_release_select → next cycle occupancy=0, o_valid=0, o_overflow=0, o_in_ready=1; no packet retained.
